// File: rtl/fir_param_engine_if.sv
// Control and sample-RAM signals of the FIR engine. The master side is the
// register block plus RAM; the slave side is the engine.
interface fir_param_engine_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 5,
    parameter int ADDR_W = 10
);
    localparam int IDX_W = $clog2(TAPS);

    logic                     start;
    logic [ADDR_W-1:0]        input_addr;
    logic [ADDR_W-1:0]        output_addr;
    logic [ADDR_W-1:0]        sample_count;
    logic                     coef_we;
    logic [IDX_W-1:0]         coef_idx;
    logic signed [COEF_W-1:0] coef_data;
    logic                     busy;
    logic                     done;
    logic                     sat_flag;
    logic [ADDR_W-1:0]        mem_addr_a;
    logic signed [DATA_W-1:0] mem_data_out_a;
    logic [ADDR_W-1:0]        mem_addr_b;
    logic signed [DATA_W-1:0] mem_data_in_b;
    logic                     mem_we_b;

    modport master (
        output start, input_addr, output_addr, sample_count,
        output coef_we, coef_idx, coef_data,
        input  busy, done, sat_flag,
        input  mem_addr_a, output mem_data_out_a,
        input  mem_addr_b, mem_data_in_b, mem_we_b
    );

    modport slave (
        input  start, input_addr, output_addr, sample_count,
        input  coef_we, coef_idx, coef_data,
        output busy, done, sat_flag,
        output mem_addr_a, input mem_data_out_a,
        output mem_addr_b, mem_data_in_b, mem_we_b
    );
endinterface

// File: rtl/fir_param_engine.sv
// Memory-to-memory FIR engine: streams N samples from RAM port A through a
// TAPS-deep filter, rounds/saturates and writes results through port B.
//
// state | meaning
// IDLE  | waiting for start; coefficients writable
// READ  | one sample read issued per cycle, n = 0..N-1
// DRAIN | reads finished, pipeline emptying into writes
// DONE  | single cycle after the last write; done rises next cycle
module fir_param_engine #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 5,
    parameter int ADDR_W = 10,
    parameter int SHIFT  = 3
) (
    input logic               clk,
    input logic               rst_n,
    fir_param_engine_if.slave bus
);
    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    // One spare bit so the rounding constant can never wrap the sum.
    localparam int RND_W  = ACC_W + 1;
    localparam logic signed [RND_W-1:0] RND_ADD =
        (SHIFT > 0) ? (RND_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((longint'(1) << (DATA_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                   state_q;
    logic [ADDR_W-1:0]        cnt_q, rd_cnt_q, rd_addr_q, wr_addr_q, mem_addr_b_q;
    logic                     busy_q, done_q, sat_q, we_q, wr_last_q;
    logic signed [DATA_W-1:0] wdata_q;
    logic [3:0]               vld_q, lst_q;

    logic signed [DATA_W-1:0] dline_q [TAPS];
    logic signed [COEF_W-1:0] coef_q  [TAPS];
    logic signed [PROD_W-1:0] prod_q  [TAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [RND_W-1:0]  rnd_d;
    logic signed [DATA_W-1:0] quant_d;
    logic                     clip_d;

    logic start_ok, rd_last;
    assign start_ok = (state_q == IDLE) && bus.start;
    assign rd_last  = (rd_cnt_q == cnt_q - 1'b1);

    always_comb begin
        acc_d = '0;
        for (int k = 0; k < TAPS; k++) acc_d = acc_d + ACC_W'(prod_q[k]);
    end

    always_comb begin
        rnd_d   = (RND_W'(acc_q) + RND_ADD) >>> SHIFT;
        quant_d = rnd_d[DATA_W-1:0];
        clip_d  = 1'b0;
        if (rnd_d > SAT_MAX) begin
            quant_d = SAT_MAX[DATA_W-1:0];
            clip_d  = 1'b1;
        end else if (rnd_d < SAT_MIN) begin
            quant_d = SAT_MIN[DATA_W-1:0];
            clip_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) coef_q[k] <= '0;
        end else if (bus.coef_we && !busy_q) begin
            for (int k = 0; k < TAPS; k++)
                if (bus.coef_idx == IDX_W'(k)) coef_q[k] <= bus.coef_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                dline_q[k] <= '0;
                prod_q[k]  <= '0;
            end
            acc_q <= '0;
        end else begin
            if (start_ok) begin
                for (int k = 0; k < TAPS; k++) dline_q[k] <= '0;
            end else if (vld_q[0]) begin
                dline_q[0] <= bus.mem_data_out_a;
                for (int k = 1; k < TAPS; k++) dline_q[k] <= dline_q[k-1];
            end
            for (int k = 0; k < TAPS; k++)
                prod_q[k] <= PROD_W'(dline_q[k]) * PROD_W'(coef_q[k]);
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_cnt_q     <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            mem_addr_b_q <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            wr_last_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sat_q        <= 1'b0;
            vld_q        <= '0;
            lst_q        <= '0;
        end else begin
            // vld/lst track each read through data, window, product and sum stages.
            vld_q     <= {vld_q[2:0], state_q == READ};
            lst_q     <= {lst_q[2:0], (state_q == READ) && rd_last};
            we_q      <= vld_q[3];
            wr_last_q <= lst_q[3];
            if (vld_q[3]) begin
                mem_addr_b_q <= wr_addr_q;
                wr_addr_q    <= wr_addr_q + 1'b1;
                wdata_q      <= quant_d;
                if (clip_d) sat_q <= 1'b1;
            end else begin
                mem_addr_b_q <= '0;
                wdata_q      <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cnt_q     <= bus.sample_count;
                        rd_cnt_q  <= '0;
                        wr_addr_q <= bus.output_addr;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        sat_q     <= 1'b0;
                        if (bus.sample_count == '0) begin
                            state_q <= DONE;
                        end else begin
                            state_q   <= READ;
                            rd_addr_q <= bus.input_addr;
                        end
                    end
                end
                READ: begin
                    if (rd_last) begin
                        state_q   <= DRAIN;
                        rd_addr_q <= '0;
                    end else begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                        rd_cnt_q  <= rd_cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (we_q && wr_last_q) state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.sat_flag      = sat_q;
    assign bus.mem_addr_a    = rd_addr_q;
    assign bus.mem_addr_b    = mem_addr_b_q;
    assign bus.mem_data_in_b = wdata_q;
    assign bus.mem_we_b      = we_q;
endmodule

// File: tb/tb_fir_param_engine.sv
// Scoreboard bench: instance A uses default parameters for directed cases,
// instance B the wide 9-tap configuration for a randomised regression.
module tb_fir_param_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {int addr; int data; int cyc;} wr_t;
    wr_t qa[$];
    wr_t qb[$];
    wr_t ea, eb;
    int  wcnt [2];
    int  h    [2][9];
    int  mem  [2][1024];

    fir_param_engine_if #(.DATA_W(8),  .COEF_W(8),  .TAPS(5), .ADDR_W(10)) bus_a ();
    fir_param_engine_if #(.DATA_W(12), .COEF_W(10), .TAPS(9), .ADDR_W(10)) bus_b ();

    fir_param_engine #(.DATA_W(8), .COEF_W(8), .TAPS(5), .ADDR_W(10), .SHIFT(3))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    fir_param_engine #(.DATA_W(12), .COEF_W(10), .TAPS(9), .ADDR_W(10), .SHIFT(6))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Sample RAMs with a bench-side load port used only while the engines idle.
    logic               ld_we_a, ld_we_b;
    logic [9:0]         ld_addr_a, ld_addr_b;
    logic signed [7:0]  ld_data_a;
    logic signed [11:0] ld_data_b;
    logic signed [7:0]  ram_a [1024];
    logic signed [11:0] ram_b [1024];

    always @(posedge clk) begin
        bus_a.mem_data_out_a <= ram_a[bus_a.mem_addr_a];
        if (ld_we_a) ram_a[ld_addr_a] <= ld_data_a;
        else if (bus_a.mem_we_b) ram_a[bus_a.mem_addr_b] <= bus_a.mem_data_in_b;
    end
    always @(posedge clk) begin
        bus_b.mem_data_out_a <= ram_b[bus_b.mem_addr_a];
        if (ld_we_b) ram_b[ld_addr_b] <= ld_data_b;
        else if (bus_b.mem_we_b) ram_b[bus_b.mem_addr_b] <= bus_b.mem_data_in_b;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus_a.mem_we_b) begin
            wcnt[0]++;
            if (qa.size() == 0) begin
                tests++; fails++;
                $display("FAIL a_unexpected_write: addr %0d data %0d, expected no write",
                         bus_a.mem_addr_b, bus_a.mem_data_in_b);
            end else begin
                ea = qa.pop_front();
                chk("a_wr_addr", bus_a.mem_addr_b, ea.addr);
                chk("a_wr_data", bus_a.mem_data_in_b, ea.data);
                chk("a_wr_cycle", cyc, ea.cyc);
            end
        end
    end
    always @(negedge clk) begin
        if (bus_b.mem_we_b) begin
            wcnt[1]++;
            if (qb.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_unexpected_write: addr %0d data %0d, expected no write",
                         bus_b.mem_addr_b, bus_b.mem_data_in_b);
            end else begin
                eb = qb.pop_front();
                chk("b_wr_addr", bus_b.mem_addr_b, eb.addr);
                chk("b_wr_data", bus_b.mem_data_in_b, eb.data);
                chk("b_wr_cycle", cyc, eb.cyc);
            end
        end
    end

    function automatic logic get_busy(int w); return (w == 1) ? bus_b.busy : bus_a.busy; endfunction
    function automatic logic get_done(int w); return (w == 1) ? bus_b.done : bus_a.done; endfunction
    function automatic logic get_sat(int w);  return (w == 1) ? bus_b.sat_flag : bus_a.sat_flag; endfunction

    task automatic load(input int w, input int base, input int vals[$]);
        foreach (vals[i]) begin
            @(negedge clk);
            if (w == 1) begin
                ld_we_b = 1'b1; ld_addr_b = 10'((base + i) & 1023); ld_data_b = 12'(vals[i]);
            end else begin
                ld_we_a = 1'b1; ld_addr_a = 10'((base + i) & 1023); ld_data_a = 8'(vals[i]);
            end
            mem[w][(base + i) & 1023] = vals[i];
        end
        @(negedge clk);
        ld_we_a = 1'b0;
        ld_we_b = 1'b0;
    endtask

    task automatic setc(input int w, input int idx, input int val, input bit apply);
        @(negedge clk);
        if (w == 1) begin
            bus_b.coef_we = 1'b1; bus_b.coef_idx = 4'(idx); bus_b.coef_data = 10'(val);
        end else begin
            bus_a.coef_we = 1'b1; bus_a.coef_idx = 3'(idx); bus_a.coef_data = 8'(val);
        end
        if (apply) h[w][idx] = val;
        @(negedge clk);
        bus_a.coef_we = 1'b0;
        bus_b.coef_we = 1'b0;
    endtask

    // Reference: direct convolution over the bench's own copy of RAM.
    task automatic expect_run(input int w, input int in, input int out, input int n,
                              input int t0, output bit esat, output int ys[$]);
        int taps, dw, sh;
        longint acc, mx;
        wr_t e;
        taps = (w == 1) ? 9 : 5;
        dw   = (w == 1) ? 12 : 8;
        sh   = (w == 1) ? 6 : 3;
        mx   = (longint'(1) << (dw - 1)) - 1;
        esat = 1'b0;
        ys.delete();
        for (int i = 0; i < n; i++) begin
            acc = 0;
            for (int k = 0; k < taps; k++)
                if (i >= k) acc += longint'(h[w][k]) * mem[w][(in + i - k) & 1023];
            if (sh > 0) acc += longint'(1) << (sh - 1);
            acc = acc >>> sh;
            if (acc > mx) begin acc = mx; esat = 1'b1; end
            else if (acc < -mx - 1) begin acc = -mx - 1; esat = 1'b1; end
            ys.push_back(int'(acc));
            e.addr = (out + i) & 1023;
            e.data = int'(acc);
            e.cyc  = t0 + 6 + i;
            if (w == 1) qb.push_back(e); else qa.push_back(e);
        end
    endtask

    task automatic drive_start(input int w, input int in, input int out, input int n);
        if (w == 1) begin
            bus_b.start = 1'b1; bus_b.input_addr = 10'(in);
            bus_b.output_addr = 10'(out); bus_b.sample_count = 10'(n);
        end else begin
            bus_a.start = 1'b1; bus_a.input_addr = 10'(in);
            bus_a.output_addr = 10'(out); bus_a.sample_count = 10'(n);
        end
    endtask

    task automatic run(input int w, input int in, input int out, input int n,
                       input bit hazard, input bit cw_same, input int cidx, input int cval,
                       output int ys[$]);
        int    t0, wbase;
        bit    esat, got, pb;
        string nm;
        nm = (w == 1) ? "b_" : "a_";
        @(negedge clk);
        drive_start(w, in, out, n);
        if (cw_same) begin
            bus_a.coef_we = 1'b1; bus_a.coef_idx = 3'(cidx); bus_a.coef_data = 8'(cval);
            h[w][cidx] = cval;
        end
        t0 = cyc;
        wbase = wcnt[w];
        expect_run(w, in, out, n, t0, esat, ys);
        @(negedge clk);
        bus_a.start = 1'b0; bus_b.start = 1'b0; bus_a.coef_we = 1'b0;
        if (hazard) begin
            repeat (3) @(negedge clk);
            drive_start(w, 5, 900, 3);
            @(negedge clk);
            bus_a.start = 1'b0; bus_b.start = 1'b0;
            bus_a.coef_we = 1'b1; bus_a.coef_idx = 3'd1; bus_a.coef_data = 8'sd55;
            @(negedge clk);
            bus_a.coef_we = 1'b0;
        end
        pb  = get_busy(w);
        got = 1'b0;
        for (int c = 0; c < n + 40 && !got; c++) begin
            @(negedge clk);
            if (get_done(w)) got = 1'b1;
            else pb = get_busy(w);
        end
        chk({nm, "done_seen"}, got, 1);
        if (got) begin
            chk({nm, "done_cycle"}, cyc - t0, (n == 0) ? 2 : n + 7);
            chk({nm, "busy_in_done_state"}, pb, 1);
            chk({nm, "busy_after_done"}, get_busy(w), 0);
            chk({nm, "sat_flag"}, get_sat(w), esat);
        end
        chk({nm, "write_count"}, wcnt[w] - wbase, n);
        chk({nm, "pending_writes"}, (w == 1) ? qb.size() : qa.size(), 0);
        foreach (ys[i]) mem[w][(out + i) & 1023] = ys[i];
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_busy"}, bus_a.busy, 0);
        chk({nm, "_done"}, bus_a.done, 0);
        chk({nm, "_sat"}, bus_a.sat_flag, 0);
        chk({nm, "_we_b"}, bus_a.mem_we_b, 0);
        chk({nm, "_addr_a"}, bus_a.mem_addr_a, 0);
        chk({nm, "_addr_b"}, bus_a.mem_addr_b, 0);
        chk({nm, "_data_b"}, bus_a.mem_data_in_b, 0);
    endtask

    initial begin
        int v[$];
        int ys[$];
        int exp_v[$];
        int t0, wb;
        bit es;
        bus_a.start = 0; bus_a.input_addr = 0; bus_a.output_addr = 0; bus_a.sample_count = 0;
        bus_a.coef_we = 0; bus_a.coef_idx = 0; bus_a.coef_data = 0;
        bus_b.start = 0; bus_b.input_addr = 0; bus_b.output_addr = 0; bus_b.sample_count = 0;
        bus_b.coef_we = 0; bus_b.coef_idx = 0; bus_b.coef_data = 0;
        ld_we_a = 0; ld_we_b = 0; ld_addr_a = 0; ld_addr_b = 0; ld_data_a = 0; ld_data_b = 0;
        wcnt[0] = 0; wcnt[1] = 0;
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 9; k++) h[w][k] = 0;
            for (int a = 0; a < 1024; a++) mem[w][a] = 0;
        end

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Impulse through the symmetric 5-tap kernel.
        v = '{8, 16, 24, 16, 8};
        foreach (v[k]) setc(0, k, v[k], 1'b1);
        v = '{8, 0, 0, 0, 0, 0, 0};
        load(0, 200, v);
        run(0, 200, 300, 7, 1'b0, 1'b0, 0, 0, ys);
        exp_v = '{8, 16, 24, 16, 8, 0, 0};
        foreach (exp_v[i]) chk("impulse_ram", ram_a[300 + i], exp_v[i]);

        // Rounding and saturation in both directions.
        v = '{127, 0, 0, 0, 0};
        foreach (v[k]) setc(0, k, v[k], 1'b1);
        v = '{100, -100, 4};
        load(0, 500, v);
        run(0, 500, 510, 3, 1'b0, 1'b0, 0, 0, ys);
        exp_v = '{127, -128, 64};
        foreach (exp_v[i]) chk("sat_ram", ram_a[510 + i], exp_v[i]);
        chk("sat_flag_set", bus_a.sat_flag, 1);

        run(0, 0, 600, 0, 1'b0, 1'b0, 0, 0, ys);

        v = '{37};
        load(0, 1023, v);
        run(0, 1023, 700, 1, 1'b0, 1'b0, 0, 0, ys);

        for (int k = 0; k < 5; k++) setc(0, k, int'($urandom_range(255)) - 128, 1'b1);
        v.delete();
        for (int i = 0; i < 4; i++) v.push_back(int'($urandom_range(255)) - 128);
        load(0, 1022, v);
        run(0, 1022, 710, 4, 1'b0, 1'b0, 0, 0, ys);

        // In place, with a stray start and a coefficient write while busy.
        for (int k = 0; k < 5; k++) setc(0, k, int'($urandom_range(63)) - 32, 1'b1);
        v.delete();
        for (int i = 0; i < 20; i++) v.push_back(int'($urandom_range(255)) - 128);
        load(0, 100, v);
        run(0, 100, 100, 20, 1'b1, 1'b0, 0, 0, ys);
        foreach (ys[i]) chk("inplace_ram", ram_a[100 + i], ys[i]);

        // Out-of-range indices are dropped; old coefficients must still be in use.
        setc(0, 5, 77, 1'b0);
        setc(0, 7, -3, 1'b0);
        v.delete();
        for (int i = 0; i < 10; i++) v.push_back(int'($urandom_range(255)) - 128);
        load(0, 130, v);
        run(0, 130, 140, 10, 1'b0, 1'b0, 0, 0, ys);

        v.delete();
        for (int i = 0; i < 8; i++) v.push_back(int'($urandom_range(255)) - 128);
        load(0, 150, v);
        run(0, 150, 160, 8, 1'b0, 1'b1, 2, -50, ys);

        // Reset in cycle 8 of a 20-sample run.
        v.delete();
        for (int i = 0; i < 20; i++) v.push_back(int'($urandom_range(255)) - 128);
        load(0, 400, v);
        @(negedge clk);
        drive_start(0, 400, 450, 20);
        t0 = cyc;
        wb = wcnt[0];
        expect_run(0, 400, 450, 20, t0, es, ys);
        @(negedge clk);
        bus_a.start = 1'b0;
        while (cyc < t0 + 8) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        chk("abort_writes_before_reset", wcnt[0] - wb, 2);
        qa.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int w = 0; w < 2; w++) for (int k = 0; k < 9; k++) h[w][k] = 0;

        for (int k = 0; k < 5; k++) setc(0, k, int'($urandom_range(255)) - 128, 1'b1);
        run(0, 400, 450, 20, 1'b0, 1'b0, 0, 0, ys);

        // Wide regression on instance B: full-range then small coefficients.
        for (int k = 0; k < 9; k++) setc(1, k, int'($urandom_range(1023)) - 512, 1'b1);
        v.delete();
        for (int i = 0; i < 256; i++) v.push_back(int'($urandom_range(4095)) - 2048);
        load(1, 300, v);
        run(1, 300, 600, 256, 1'b0, 1'b0, 0, 0, ys);
        for (int k = 0; k < 9; k++) setc(1, k, int'($urandom_range(8)) - 4, 1'b1);
        run(1, 300, 600, 256, 1'b0, 1'b0, 0, 0, ys);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
